// File: rtl/mem_access.sv
// mem_access: pipeline memory stage between exe_mem and mem_wb.
// Issues one bus access at a time (req/gnt then rvalid), formats load data and
// store byte enables, and stalls the pipeline until the access completes.
// Non-memory instructions pass straight through with zero latency.
// Optional build macro MEM_BUS_TIMEOUT_EN: aborts an access that has spent
// TIMEOUT_CYCLES cycles in REQ/WAIT and pulses bus_err_o.
//
// Bus handshake: bus_req_o and the bus_* fields are registered and held stable
// from the cycle after issue until the cycle bus_gnt_i is seen high; the
// request is then dropped and exactly one bus_rvalid_i (at least one cycle
// after the grant) completes the access. gnt/rvalid outside REQ/WAIT are ignored.

`ifndef MEM_NOP
`define MEM_NOP 4'd0
`endif
`ifndef LB
`define LB 4'd1
`endif
`ifndef LH
`define LH 4'd2
`endif
`ifndef LW
`define LW 4'd3
`endif
`ifndef LBU
`define LBU 4'd4
`endif
`ifndef LHU
`define LHU 4'd5
`endif
`ifndef SB
`define SB 4'd6
`endif
`ifndef SH
`define SH 4'd7
`endif
`ifndef SW
`define SW 4'd8
`endif

module mem_access #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int RADDR_WIDTH    = 5,
  parameter int CSR_ADDR_WIDTH = 12,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [RADDR_WIDTH-1:0]    reg_waddr_i,
  input  logic                      reg_we_i,
  input  logic [DATA_WIDTH-1:0]     reg_wdata_i,
  input  logic [ADDR_WIDTH-1:0]     mem_addr_i,
  input  logic [DATA_WIDTH-1:0]     mem_data_i,
  input  logic                      mem_we_i,
  input  logic [3:0]                mem_op_i,
  input  logic                      csr_we_i,
  input  logic [CSR_ADDR_WIDTH-1:0] csr_waddr_i,
  input  logic [DATA_WIDTH-1:0]     csr_wdata_i,
  input  logic                      stall_i,
  output logic [RADDR_WIDTH-1:0]    reg_waddr_o,
  output logic                      reg_we_o,
  output logic [DATA_WIDTH-1:0]     reg_wdata_o,
  output logic                      csr_we_o,
  output logic [CSR_ADDR_WIDTH-1:0] csr_waddr_o,
  output logic [DATA_WIDTH-1:0]     csr_wdata_o,
  output logic                      stallreq_o,
  output logic                      misalign_o,
  output logic                      bus_req_o,
  output logic [ADDR_WIDTH-1:0]     bus_addr_o,
  output logic                      bus_we_o,
  output logic [3:0]                bus_be_o,
  output logic [DATA_WIDTH-1:0]     bus_wdata_o,
  input  logic                      bus_gnt_i,
  input  logic                      bus_rvalid_i,
  input  logic [DATA_WIDTH-1:0]     bus_rdata_i,
  output logic                      bus_err_o,
  output logic [1:0]                state_dbg_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t r_state, w_next;

  // Latched op and byte lane of the access in flight
  logic [3:0] r_op;
  logic [1:0] r_lane;

  // Registered bus request fields
  logic                  r_bus_req;
  logic [ADDR_WIDTH-1:0] r_bus_addr;
  logic                  r_bus_we;
  logic [3:0]            r_bus_be;
  logic [DATA_WIDTH-1:0] r_bus_wdata;

  // Hold register for results while mem_wb is not advancing
  logic [RADDR_WIDTH-1:0]    r_h_waddr;
  logic                      r_h_we;
  logic [DATA_WIDTH-1:0]     r_h_wdata;
  logic                      r_h_csr_we;
  logic [CSR_ADDR_WIDTH-1:0] r_h_csr_waddr;
  logic [DATA_WIDTH-1:0]     r_h_csr_wdata;

  logic                  w_is_load, w_is_store, w_mem_op, w_misalign;
  logic                  w_issue, w_end, w_abort, w_timeout;
  logic [3:0]            w_be;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [DATA_WIDTH-1:0] w_load_data;
  logic [7:0]            w_rbyte;
  logic [15:0]           w_rhalf;
  logic                  w_r_is_load;

  // Decode the incoming exe_mem request
  always_comb begin
    w_is_load  = 1'b0;
    w_is_store = 1'b0;
    w_misalign = 1'b0;
    w_be       = 4'b1111;
    w_wdata    = '0;
    case (mem_op_i)
      `LB, `LBU: w_is_load = 1'b1;
      `LH, `LHU: begin
        w_is_load  = 1'b1;
        w_misalign = mem_addr_i[0];
      end
      `LW: begin
        w_is_load  = 1'b1;
        w_misalign = |mem_addr_i[1:0];
      end
      `SB: begin
        w_is_store = mem_we_i;
        w_be       = 4'b0001 << mem_addr_i[1:0];
        w_wdata    = {(DATA_WIDTH/8){mem_data_i[7:0]}};
      end
      `SH: begin
        w_is_store = mem_we_i;
        w_misalign = mem_addr_i[0];
        w_be       = 4'b0011 << {mem_addr_i[1], 1'b0};
        w_wdata    = {(DATA_WIDTH/16){mem_data_i[15:0]}};
      end
      `SW: begin
        w_is_store = mem_we_i;
        w_misalign = |mem_addr_i[1:0];
        w_wdata    = mem_data_i;
      end
      default: ;
    endcase
    w_mem_op = w_is_load | w_is_store;
  end

  // Extract and extend the addressed lane of the read data
  assign w_rbyte = bus_rdata_i[{r_lane, 3'b000} +: 8];
  assign w_rhalf = bus_rdata_i[{r_lane[1], 4'b0000} +: 16];

  always_comb begin
    w_load_data = bus_rdata_i;
    w_r_is_load = 1'b1;
    case (r_op)
      `LB:     w_load_data = {{(DATA_WIDTH-8){w_rbyte[7]}}, w_rbyte};
      `LBU:    w_load_data = {{(DATA_WIDTH-8){1'b0}}, w_rbyte};
      `LH:     w_load_data = {{(DATA_WIDTH-16){w_rhalf[15]}}, w_rhalf};
      `LHU:    w_load_data = {{(DATA_WIDTH-16){1'b0}}, w_rhalf};
      `LW:     w_load_data = bus_rdata_i;
      default: w_r_is_load = 1'b0;
    endcase
  end

`ifdef MEM_BUS_TIMEOUT_EN
  localparam int TmoW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [TmoW-1:0] r_tmo_cnt;

  // Count cycles spent in REQ/WAIT; restarts at each issue
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_tmo_cnt <= '0;
    end else if (w_issue) begin
      r_tmo_cnt <= '0;
    end else if ((r_state == S_REQ) || (r_state == S_WAIT)) begin
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end

  assign w_timeout = ((r_state == S_REQ) || (r_state == S_WAIT)) &&
                     (r_tmo_cnt == TmoW'(TIMEOUT_CYCLES - 1));
`else
  // No timeout in this build: the access waits for its response indefinitely
  assign w_timeout = 1'b0 & (TIMEOUT_CYCLES < 0);
`endif

  // Next state and pipeline-facing outputs
  always_comb begin
    w_next      = r_state;
    reg_waddr_o = reg_waddr_i;
    reg_we_o    = reg_we_i;
    reg_wdata_o = reg_wdata_i;
    csr_we_o    = csr_we_i;
    csr_waddr_o = csr_waddr_i;
    csr_wdata_o = csr_wdata_i;
    stallreq_o  = 1'b0;
    misalign_o  = 1'b0;
    w_issue     = 1'b0;
    w_end       = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_mem_op) begin
          reg_we_o = 1'b0;
          if (w_misalign) begin
            misalign_o = 1'b1;
          end else begin
            stallreq_o = 1'b1;
            w_issue    = 1'b1;
            w_next     = S_REQ;
          end
        end
      end
      S_REQ: begin
        reg_we_o = 1'b0;
        if (w_timeout) begin
          w_abort = 1'b1;
          w_end   = 1'b1;
        end else begin
          stallreq_o = 1'b1;
          if (bus_gnt_i) w_next = S_WAIT;
        end
      end
      S_WAIT: begin
        reg_we_o = 1'b0;
        if (bus_rvalid_i) begin
          w_end = 1'b1;
          if (w_r_is_load) begin
            reg_we_o    = reg_we_i;
            reg_wdata_o = w_load_data;
          end
        end else if (w_timeout) begin
          w_abort = 1'b1;
          w_end   = 1'b1;
        end else begin
          stallreq_o = 1'b1;
        end
      end
      S_HOLD: begin
        reg_waddr_o = r_h_waddr;
        reg_we_o    = r_h_we;
        reg_wdata_o = r_h_wdata;
        csr_we_o    = r_h_csr_we;
        csr_waddr_o = r_h_csr_waddr;
        csr_wdata_o = r_h_csr_wdata;
        if (!stall_i) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    if (w_end) w_next = stall_i ? S_HOLD : S_IDLE;
  end

  assign bus_err_o = w_abort;

  // State register and latched op of the access in flight
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_op    <= `MEM_NOP;
      r_lane  <= 2'b00;
    end else begin
      r_state <= w_next;
      if (w_issue) begin
        r_op   <= mem_op_i;
        r_lane <= mem_addr_i[1:0];
      end
    end
  end

  // Bus request fields: loaded on issue, request dropped on grant or abort
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_bus_req   <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_we    <= 1'b0;
      r_bus_be    <= 4'b0000;
      r_bus_wdata <= '0;
    end else if (w_issue) begin
      r_bus_req   <= 1'b1;
      r_bus_addr  <= {mem_addr_i[ADDR_WIDTH-1:2], 2'b00};
      r_bus_we    <= w_is_store;
      r_bus_be    <= w_be;
      r_bus_wdata <= w_wdata;
    end else if ((r_state == S_REQ) && (bus_gnt_i || w_abort)) begin
      r_bus_req <= 1'b0;
    end
  end

  // Capture the completing result when mem_wb is not advancing
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_h_waddr     <= '0;
      r_h_we        <= 1'b0;
      r_h_wdata     <= '0;
      r_h_csr_we    <= 1'b0;
      r_h_csr_waddr <= '0;
      r_h_csr_wdata <= '0;
    end else if (w_end && stall_i) begin
      r_h_waddr     <= reg_waddr_o;
      r_h_we        <= reg_we_o;
      r_h_wdata     <= reg_wdata_o;
      r_h_csr_we    <= csr_we_o;
      r_h_csr_waddr <= csr_waddr_o;
      r_h_csr_wdata <= csr_wdata_o;
    end
  end

  assign bus_req_o   = r_bus_req;
  assign bus_addr_o  = r_bus_addr;
  assign bus_we_o    = r_bus_we;
  assign bus_be_o    = r_bus_be;
  assign bus_wdata_o = r_bus_wdata;
  assign state_dbg_o = r_state;

endmodule
